// File: rtl/bus_uart_tx_pkg.sv
// Shared register map, status layout and FSM encoding
// for the memory-mapped UART transmitter.
package bus_uart_tx_pkg;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_1000_0000;

  localparam logic [4:0] UART_TXDATA = 5'h00;
  localparam logic [4:0] UART_STATUS = 5'h08;
  localparam logic [4:0] UART_CTRL   = 5'h10;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// Byte-wide synchronous FIFO, power-of-two depth,
// combinational read of the head entry.
module sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO,
// status/control registers and drain interrupt.
module bus_uart_tx
  import bus_uart_tx_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic        uart_tx,
  output logic        irq
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          ctrl_ie;
  logic          overflow;

  logic          hit;
  logic [4:0]    off;
  logic          wr_tx;
  logic          wr_ctrl;
  logic          rd_status;
  logic          bit_last;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic [NW-1:0] fifo_count;
  logic [63:0]   status;
  logic [63:0]   rdata;
  logic          unused_wdata;

  assign hit       = bus_address[63:5] == BASE_ADDR[63:5];
  assign off       = bus_address[4:0];
  assign wr_tx     = bus_write_enable & hit & (off == UART_TXDATA);
  assign wr_ctrl   = bus_write_enable & hit & (off == UART_CTRL);
  assign rd_status = bus_read_enable & hit & (off == UART_STATUS);
  assign bit_last  = bit_cnt == BIT_LAST;
  assign unused_wdata = ^bus_write_data[63:8];

  // Pop from IDLE, or on the final stop cycle for gapless frames
  assign pop = ~fifo_empty &
               ((state == S_IDLE) |
                ((state == S_STOP) & bit_last));

  sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx & ~fifo_full),
    .din   (bus_write_data[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status = '0;
    status[ST_BUSY]  = state != S_IDLE;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF]   = overflow;
    status[ST_CNT_LSB +: 8] = 8'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      off == UART_STATUS: rdata = status;
      off == UART_CTRL:   rdata = {63'b0, ctrl_ie};
      default:            rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_read_data <= '0;
      ctrl_ie       <= 1'b0;
      overflow      <= 1'b0;
      irq           <= 1'b0;
    end else begin
      if (bus_read_enable)
        bus_read_data <= hit ? rdata : '0;
      if (wr_ctrl)
        ctrl_ie <= bus_write_data[0];
      if (wr_tx & fifo_full)
        overflow <= 1'b1;
      else if (rd_status)
        overflow <= 1'b0;
      irq <= ctrl_ie & fifo_empty & (state == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          bit_cnt <= '0;
          if (pop) begin
            shift_reg <= fifo_dout;
            state     <= S_START;
            uart_tx   <= 1'b0;
          end
        end
        S_START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            uart_tx <= shift_reg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (pop) begin
              shift_reg <= fifo_dout;
              state     <= S_START;
              uart_tx   <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_uart_tx.md
Name: bus_uart_tx

Overview:
- Memory-mapped UART transmitter. Sits on the core's 64-bit data bus, downstream of the CPU's load/store path.
- Consumes core stores into a byte FIFO and serialises them 8N1 on uart_tx.
- Provides status and control registers for core loads.
- Drives a level interrupt to the interrupt front end when the transmitter drains.

Parameters:
- BASE_ADDR, 64'h0000_0000_1000_0000, 32-byte-aligned base of register window
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200)
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- bus_address  in  64  byte address from core
- bus_write_data  in  64  store data; only [7:0] used
- bus_write_enable  in  1  store strobe, one cycle per store
- bus_read_enable  in  1  load strobe, one cycle per load
- bus_read_data  out  64  registered load data
- uart_tx  out  1  serial line, idle high
- irq  out  1  level interrupt request

Behaviour:
- Address decode:
  - hit = bus_address[63:5] == BASE_ADDR[63:5].
  - Offset bus_address[4:0]: 0x00 TXDATA, 0x08 STATUS, 0x10 CTRL. Other offsets are ignored; reads of them return 0.
- Reset (reset low at a clk edge): uart_tx=1, irq=0, bus_read_data=0, FIFO empty, FSM IDLE, ctrl_ie=0, overflow=0. Reset mid-frame aborts the frame, uart_tx is high after that edge, and queued bytes are discarded.
- Writes:
  - TXDATA: on an edge with bus_write_enable & hit & offset 0x00, push bus_write_data[7:0] if the FIFO is not full.
  - Full is evaluated on the pre-edge count. A push while full is dropped and sets overflow, even if a pop happens at the same edge.
  - CTRL: a write sets ctrl_ie = bus_write_data[0].
  - A write to STATUS has no effect.
- Reads:
  - On an edge with bus_read_enable & hit, bus_read_data <= the selected register, zero-extended.
  - On an edge with bus_read_enable & !hit, bus_read_data <= 0, so the result can be OR-combined with other slaves.
  - With no bus_read_enable, bus_read_data holds its value.
  - Data is valid from the edge after the strobe and stays stable through the core's bubble cycle.
- STATUS fields: [0] busy (FSM != IDLE), [1] full, [2] empty, [3] overflow, [11:4] fifo count, rest 0.
  - A read of STATUS returns the pre-edge value and clears overflow at that edge.
  - If overflow is set and cleared at the same edge, set wins.
- TXDATA reads return 0. CTRL reads return {63'b0, ctrl_ie}.
- Simultaneous bus_read_enable and bus_write_enable: both are serviced.
- FSM states: IDLE, START, DATA, STOP. bit_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop into shift_reg and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: uart_tx=shift_reg[bit_idx], LSB first, CLKS_PER_BIT cycles per bit; after bit 7 go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Latency:
  - Store accepted at edge E0 (FIFO count 1 after E0).
  - Pop at E1; uart_tx low after E1.
  - Frame is exactly 10*CLKS_PER_BIT cycles.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1. A simultaneous push and pop leaves count unchanged.
- irq is registered: irq <= ctrl_ie & empty & (FSM==IDLE), updated every edge. It deasserts the edge after a push or after ctrl_ie is cleared.

Decomposition:
- Shared header.vh gets:
  - UART register offset defines: UART_TXDATA=0x00, UART_STATUS=0x08, UART_CTRL=0x10
  - STATUS bit positions
  - FSM state encodings (2-bit)
  - default BASE_ADDR
- One sub-module: sync_fifo, a byte-wide synchronous FIFO.
  - Parameters: DEPTH.
  - Ports: push, din, pop, dout, full, empty, count. Same clk and reset.

Test Plan:
- Setup: CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset held for 2 cycles with stores active -> uart_tx=1, irq=0, bus_read_data=0, STATUS read returns 0x4 (empty).
- Store 0xA5 to BASE+0x00 -> uart_tx falls 2 edges after the strobe. Sampled bits per 4-cycle slot: 0, 1,0,1,0,0,1,0,1, 1 (start, LSB-first data, stop). Total 40 cycles, then STATUS = 0x4.
- Six back-to-back stores 0x01..0x06 while idle -> first byte pops, next four fill the FIFO (STATUS full=1, count=4), sixth is dropped. STATUS reads 0x4B (count 4, overflow, full, busy); a second STATUS read shows overflow=0. Line carries 0x01..0x05 with no idle gap between frames.
- Write CTRL=1 with the FIFO empty and idle -> irq=1 one edge later. Store 0x55 -> irq=0 the edge after the store, and irq=1 again one edge after the stop bit ends.
- Load from BASE+0x40 (miss) -> bus_read_data=0. Load CTRL -> 0x1, held stable for at least 3 cycles with no strobe.
- Reset asserted mid DATA of 0x3C with two bytes queued -> uart_tx=1 after the edge; STATUS = 0x4 after release; no further frames.
